// File: rtl/time_keeper.sv
// time_keeper: 12-hour wall clock (hour/min/sec/pm) advanced by a prescaled
// one-second tick derived from clk.
//
// Optional feature macro: ALARM_MATCH_EN
//   When defined, adds alarm_hour/alarm_min/alarm_pm/alarm_arm inputs and an
//   alarm_hit output that pulses with min_pulse when the new time matches.
//
// Ports
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   run            : 1 = time advances, 0 = time and prescaler frozen
//   load           : level load of set_hour/set_min/set_pm (sec and prescaler cleared)
//   set_hour/min/pm: values to load (out-of-range hour -> 12, min -> 59)
//   hour/min/sec/pm: current time, all registered
//   sec_pulse      : one-cycle strobe per second increment
//   min_pulse      : one-cycle strobe per minute carry (sec 59 -> 0)
module time_keeper #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic [3:0] set_hour,
  input  logic [5:0] set_min,
  input  logic       set_pm,
`ifdef ALARM_MATCH_EN
  input  logic [3:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic [0:0] alarm_pm,
  input  logic [0:0] alarm_arm,
  output logic [0:0] alarm_hit,
`endif
  output logic [3:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       pm,
  output logic       sec_pulse,
  output logic       min_pulse
);

  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] presc;

  // Clamped load values.
  logic [3:0] ld_hour;
  logic [5:0] ld_min;
  assign ld_hour = (set_hour == 4'd0 || set_hour > 4'd12) ? 4'd12 : set_hour;
  assign ld_min  = (set_min > 6'd59) ? 6'd59 : set_min;

  // Time after a minute carry (only used when sec wraps).
  logic [3:0] hour_c;
  logic [5:0] min_c;
  logic       pm_c;
  always_comb begin
    min_c  = min + 6'd1;
    hour_c = hour;
    pm_c   = pm;
    if (min == 6'd59) begin
      min_c  = 6'd0;
      hour_c = (hour == 4'd12) ? 4'd1 : hour + 4'd1;
      // 11 -> 12 is where the AM/PM half-day boundary sits.
      if (hour == 4'd11) pm_c = ~pm;
    end
  end

`ifdef ALARM_MATCH_EN
  logic alarm_match;
  assign alarm_match = alarm_arm[0] && (hour_c == alarm_hour) &&
                       (min_c == alarm_min) && (pm_c == alarm_pm[0]);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hour      <= 4'd12;
      min       <= 6'd0;
      sec       <= 6'd0;
      pm        <= 1'b0;
      presc     <= '0;
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
`ifdef ALARM_MATCH_EN
      alarm_hit <= 1'b0;
`endif
    end else begin
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
`ifdef ALARM_MATCH_EN
      alarm_hit <= 1'b0;
`endif
      if (load) begin
        // Load wins over a pending tick; no pulses, so a load that matches
        // the alarm never fires it.
        hour  <= ld_hour;
        min   <= ld_min;
        pm    <= set_pm;
        sec   <= 6'd0;
        presc <= '0;
      end else if (run) begin
        if (presc == LAST) begin
          presc     <= '0;
          sec_pulse <= 1'b1;
          if (sec == 6'd59) begin
            sec       <= 6'd0;
            min       <= min_c;
            hour      <= hour_c;
            pm        <= pm_c;
            min_pulse <= 1'b1;
`ifdef ALARM_MATCH_EN
            alarm_hit <= alarm_match;
`endif
          end else begin
            sec <= sec + 6'd1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios plus randomized traffic, all
// checked every cycle against a seconds-since-midnight reference model.
module tb_time_keeper;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset, run, load, set_pm;
  logic [3:0] set_hour;
  logic [5:0] set_min;
  logic [3:0] hour;
  logic [5:0] min, sec;
  logic       pm, sec_pulse, min_pulse;
`ifdef ALARM_MATCH_EN
  logic [3:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_pm, alarm_arm, alarm_hit;
`endif

  time_keeper #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .run(run), .load(load),
    .set_hour(set_hour), .set_min(set_min), .set_pm(set_pm),
`ifdef ALARM_MATCH_EN
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_pm(alarm_pm),
    .alarm_arm(alarm_arm), .alarm_hit(alarm_hit),
`endif
    .hour(hour), .min(min), .sec(sec), .pm(pm),
    .sec_pulse(sec_pulse), .min_pulse(min_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int sp_cnt = 0, mp_cnt = 0, ah_cnt = 0;

  // Reference model: time as seconds since midnight, prescaler as a count.
  int m_t = 0, m_pre = 0;
  bit m_sp = 0, m_mp = 0, m_ah = 0;

  function automatic int to_t(int h, int m, bit p);
    return ((h % 12) + (p ? 12 : 0)) * 3600 + m * 60;
  endfunction
  function automatic int e_hour(int t);
    int h = (t / 3600) % 12;
    return (h == 0) ? 12 : h;
  endfunction
  function automatic int e_min(int t); return (t / 60) % 60; endfunction
  function automatic int e_sec(int t); return t % 60; endfunction
  function automatic int e_pm(int t);  return (t >= 43200) ? 1 : 0; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int h, m;
    m_sp = 0; m_mp = 0; m_ah = 0;
    if (reset) begin
      m_t = 0; m_pre = 0;
    end else if (load) begin
      h = (set_hour == 0 || set_hour > 12) ? 12 : int'(set_hour);
      m = (set_min > 59) ? 59 : int'(set_min);
      m_t = to_t(h, m, set_pm);
      m_pre = 0;
    end else if (run) begin
      if (m_pre == T - 1) begin
        m_pre = 0;
        m_t = (m_t + 1) % 86400;
        m_sp = 1;
        m_mp = (m_t % 60 == 0);
`ifdef ALARM_MATCH_EN
        m_ah = m_mp && alarm_arm && e_hour(m_t) == alarm_hour &&
               e_min(m_t) == alarm_min && e_pm(m_t) == alarm_pm;
`endif
      end else begin
        m_pre++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("hour", hour, e_hour(m_t));
    chk("min", min, e_min(m_t));
    chk("sec", sec, e_sec(m_t));
    chk("pm", pm, e_pm(m_t));
    chk("sec_pulse", sec_pulse, m_sp);
    chk("min_pulse", min_pulse, m_mp);
    sp_cnt += sec_pulse;
    mp_cnt += min_pulse;
`ifdef ALARM_MATCH_EN
    chk("alarm_hit", alarm_hit, m_ah);
    ah_cnt += alarm_hit;
`endif
  endtask

  task automatic do_load(input int h, input int m, input bit p);
    load = 1; set_hour = 4'(h); set_min = 6'(m); set_pm = p;
    step();
    load = 0;
  endtask

  initial begin
    reset = 1; run = 0; load = 0; set_hour = 0; set_min = 0; set_pm = 0;
`ifdef ALARM_MATCH_EN
    alarm_hour = 0; alarm_min = 0; alarm_pm = 0; alarm_arm = 0;
`endif
    step(); step();
    chk("rst_hour", hour, 12);
    chk("rst_sec_pulse", sec_pulse, 0);
    reset = 0;

    // Eight running cycles from reset: two ticks.
    sp_cnt = 0; run = 1;
    repeat (8) step();
    chk("r8_sec", sec, 2);
    chk("r8_hour", hour, 12);
    chk("r8_pm", pm, 0);
    chk("r8_sp_cnt", sp_cnt, 2);

    // 11:59 PM + 60 s -> 12:00:00 AM.
    do_load(11, 59, 1);
    mp_cnt = 0;
    repeat (60 * T) step();
    chk("pm_wrap_hour", hour, 12);
    chk("pm_wrap_min", min, 0);
    chk("pm_wrap_pm", pm, 0);
    chk("pm_wrap_mp_last", min_pulse, 1);
    chk("pm_wrap_mp_cnt", mp_cnt, 1);

    // 12:59 AM + 60 s -> 1:00:00 AM; then clamped load.
    do_load(12, 59, 0);
    repeat (60 * T) step();
    chk("h12_wrap_hour", hour, 1);
    chk("h12_wrap_pm", pm, 0);
    do_load(0, 63, 0);
    chk("clamp_hour", hour, 12);
    chk("clamp_min", min, 59);

    // Load on a pending tick, then freeze for 10 cycles.
    repeat (T - 1) step();
    sp_cnt = 0;
    do_load(5, 30, 1);
    chk("ldtick_sec", sec, 0);
    chk("ldtick_min", min, 30);
    chk("ldtick_sp", sp_cnt, 0);
    step(); step();
    run = 0;
    repeat (10) step();
    chk("frz_sec", sec, 0);
    chk("frz_sp", sp_cnt, 0);
    run = 1;
    step();
    chk("resume_sec0", sec, 0);
    step();
    chk("resume_sec1", sec, 1);

    // Reset on the tick cycle at 11:59:59 PM.
    do_load(11, 59, 1);
    repeat (60 * T - 1) step();
    chk("pre_rst_sec", sec, 59);
    reset = 1;
    step();
    reset = 0;
    chk("tickrst_hour", hour, 12);
    chk("tickrst_min", min, 0);
    chk("tickrst_pm", pm, 0);
    chk("tickrst_sp", sec_pulse, 0);
    chk("tickrst_mp", min_pulse, 0);

`ifdef ALARM_MATCH_EN
    alarm_hour = 7; alarm_min = 1; alarm_pm = 1; alarm_arm = 1;
    do_load(7, 0, 1);
    ah_cnt = 0;
    repeat (60 * T) step();
    chk("alarm_hit_last", alarm_hit, 1);
    chk("alarm_mp_last", min_pulse, 1);
    chk("alarm_cnt", ah_cnt, 1);
    do_load(7, 1, 1);
    chk("alarm_ld_match", alarm_hit, 0);
    alarm_arm = 0;
    do_load(7, 0, 1);
    ah_cnt = 0;
    repeat (60 * T) step();
    chk("alarm_disarm_cnt", ah_cnt, 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      reset = ($urandom_range(0, 999) == 0);
      load  = ($urandom_range(0, 299) == 0);
      run   = ($urandom_range(0, 9) != 0);
      if (load) begin
        set_hour = 4'($urandom_range(0, 15));
        set_min  = $urandom_range(0, 1) ? 6'd59 : 6'($urandom_range(0, 63));
        set_pm   = 1'($urandom_range(0, 1));
`ifdef ALARM_MATCH_EN
        alarm_hour = (set_hour == 12) ? 4'd1 : set_hour + 4'd1;
        alarm_min  = 6'd0;
        alarm_pm   = (set_hour == 11) ? ~set_pm : set_pm;
        alarm_arm  = 1'($urandom_range(0, 1));
`endif
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100000000, clk cycles per one-second tick (minimum 2).
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  1 = time advances; 0 = time and prescaler frozen.
REQ-005 load  input  1  level; while 1, time registers take the set_* values.
REQ-006 set_hour  input  4  hour to load, 1..12 binary.
REQ-007 set_min  input  6  minute to load, 0..59 binary.
REQ-008 set_pm  input  1  PM flag to load (1 = PM).
REQ-009 hour  output  4  current hour, 1..12 binary.
REQ-010 min  output  6  current minute, 0..59 binary.
REQ-011 sec  output  6  current second, 0..59 binary.
REQ-012 pm  output  1  current PM flag; this is the current-time PM value consumed by the PM display mux.
REQ-013 sec_pulse  output  1  one-cycle strobe on each second increment.
REQ-014 min_pulse  output  1  one-cycle strobe on each minute carry (sec 59->0).

Function
REQ-015 The prescaler counter shall count 0..TICKS_PER_SEC-1 while run=1 and load=0; a tick occurs in the cycle the counter equals TICKS_PER_SEC-1, and the counter returns to 0 in that cycle.
REQ-016 On a tick, sec shall increment by 1, and sec_pulse shall be 1 in the following cycle only.
REQ-017 On a tick with sec=59, sec shall become 0, min shall increment, and min_pulse shall assert for one cycle together with sec_pulse.
REQ-018 On a minute carry with min=59, min shall become 0 and hour shall advance.
REQ-019 Hour advance: 12->1 with pm unchanged; 11->12 with pm toggled; any other hour h->h+1 with pm unchanged.
REQ-020 Hence 11:59:59 AM + tick = 12:00:00 PM; 11:59:59 PM + tick = 12:00:00 AM; 12:59:59 + tick = 1:00:00 with the same pm.
REQ-021 When load=1: hour<=set_hour, min<=set_min, pm<=set_pm, sec<=0, prescaler<=0, and no pulses are generated.
REQ-022 Load clamping: set_hour of 0 or greater than 12 shall load 12; set_min greater than 59 shall load 59.
REQ-023 load shall have priority over run and tick in the same cycle.
REQ-024 When load falls, counting shall restart from prescaler 0, so the first tick occurs TICKS_PER_SEC cycles after the last load cycle, provided run=1.
REQ-025 When run=0, all registers shall hold their values and both pulses shall be 0; when run returns to 1, the prescaler shall resume from its held value.
REQ-026 All outputs shall be registered; no output shall depend combinationally on any input.

Reset
REQ-027 reset=1 at a rising clk edge shall set hour=12, min=0, sec=0, pm=0, prescaler=0, sec_pulse=0, min_pulse=0, and alarm_hit=0 where present.
REQ-028 reset shall take priority over load, run and tick, including mid-count and mid-carry.

Configuration
REQ-029 Macro ALARM_MATCH_EN: when defined, the block shall add inputs alarm_hour[3:0], alarm_min[5:0], alarm_pm[0:0] and alarm_arm[0:0], and output alarm_hit[0:0].
REQ-030 With ALARM_MATCH_EN defined, alarm_hit shall pulse for one cycle, coincident with min_pulse, when alarm_arm=1 and the new hour, min and pm equal the alarm values.
REQ-031 With ALARM_MATCH_EN defined, a load that happens to match the alarm values shall not assert alarm_hit.
REQ-032 Without ALARM_MATCH_EN, the alarm ports and logic shall be absent, and all other behaviour shall be unchanged.

Verification
REQ-033 TICKS_PER_SEC=4; apply reset, then run=1 for 8 cycles -> time reads 12:00:02 AM, and sec_pulse is seen exactly twice.
REQ-034 Load 11:59 PM, release load, run for 60 ticks -> time reads 12:00:00 AM (pm=0), and min_pulse is seen once, on the 60th tick.
REQ-035 Load 12:59 AM, run for 60 ticks -> time reads 1:00:00 AM; load set_hour=0, set_min=63 -> time reads 12:59:00.
REQ-036 Assert load in the same cycle as a pending tick -> the set values are loaded with sec=0, and no sec_pulse is generated; drop run mid-count for 10 cycles -> time and prescaler are unchanged.
REQ-037 Assert reset at 11:59:59 PM during a tick cycle -> time reads 12:00:00 AM, and no pulses are generated.
REQ-038 With ALARM_MATCH_EN defined, alarm set to 7:01 PM and armed, load 7:00 PM, run for 60 ticks -> alarm_hit is seen once, on the same cycle as min_pulse; repeat with alarm_arm=0 -> alarm_hit is never seen.
